// File: rtl/arrow_scheduler_pkg.sv
// arrow_scheduler_pkg: shared arrow direction, slot and FSM types plus lane x positions
// Contents: arrow_dir_t, slot_t, sched_state_t, LANE_X (x of each lane, indexed by direction)
package arrow_scheduler_pkg;
   typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} arrow_dir_t;
   typedef struct packed {
      logic       active;
      arrow_dir_t dir;
      logic [9:0] y;
   } slot_t;
   typedef enum logic {IDLE, UPDATE} sched_state_t;
   localparam logic [10:0] LANE_X [4] = '{11'd200, 11'd350, 11'd500, 11'd650};
endpackage

// File: rtl/arrow_scheduler_if.sv
// arrow_scheduler_if: spawn handshake, player press and score pulses between game logic and scheduler
// Signals: spawn_valid_in/spawn_dir_in/spawn_ready_out, hit_in/hit_dir_in, hit_out/miss_out
// master = game side driving spawns and presses, slave = arrow_scheduler
interface arrow_scheduler_if;
   logic       spawn_valid_in;
   logic [1:0] spawn_dir_in;
   logic       spawn_ready_out;
   logic       hit_in;
   logic [1:0] hit_dir_in;
   logic       hit_out;
   logic       miss_out;
   modport master(output spawn_valid_in, spawn_dir_in, hit_in, hit_dir_in,
                  input spawn_ready_out, hit_out, miss_out);
   modport slave(input spawn_valid_in, spawn_dir_in, hit_in, hit_dir_in,
                 output spawn_ready_out, hit_out, miss_out);
endinterface

// File: rtl/arrow_scheduler_sprite_hit_test.sv
// sprite_hit_test: tests whether one slot's sprite box covers a pixel and forms its BROM address
// Ports: slot (slot state), hcount/vcount (pixel), hit (box covers pixel), addr (BROM address, valid with hit)
module sprite_hit_test
   import arrow_scheduler_pkg::*;
#(
   parameter int WIDTH  = 100,
   parameter int HEIGHT = 100,
   parameter int ADDR_W = 16
) (
   input  slot_t              slot,
   input  logic [10:0]        hcount,
   input  logic [9:0]         vcount,
   output logic               hit,
   output logic [ADDR_W-1:0]  addr
);
   logic [31:0] x, y, h, v;
   assign x = 32'(LANE_X[slot.dir]);
   assign y = 32'(slot.y);
   assign h = 32'(hcount);
   assign v = 32'(vcount);
   assign hit = slot.active && h >= x && h < x + 32'(WIDTH) && v >= y && v < y + 32'(HEIGHT);
   // the four arrow images are stacked in the BROM, one WIDTH*HEIGHT block per direction
   assign addr = ADDR_W'(32'(slot.dir) * 32'(WIDTH * HEIGHT) + (h - x) + (v - y) * 32'(WIDTH));
endmodule

// File: rtl/arrow_scheduler.sv
// arrow_scheduler: tracks falling arrow sprites, moves them each frame, scores presses and drives the sprite BROM
// Ports: pixel_clk_in/rst_in (clock, sync active-low reset), hcount_in/vcount_in (pixel),
//   new_frame_in (frame pulse), bus (spawn/hit/score interface), rom_addr_out/sprite_valid_out (sprite BROM)
module arrow_scheduler
   import arrow_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int WIDTH     = 100,
   parameter int HEIGHT    = 100,
   parameter int SCREEN_H  = 768,
   parameter int SPEED     = 2,
   parameter int TARGET_Y  = 600,
   parameter int TOL       = 20
) (
   input  logic                                  pixel_clk_in,
   input  logic                                  rst_in,
   input  logic [10:0]                           hcount_in,
   input  logic [9:0]                            vcount_in,
   input  logic                                  new_frame_in,
   arrow_scheduler_if.slave                      bus,
   output logic [$clog2(4*WIDTH*HEIGHT)-1:0]     rom_addr_out,
   output logic                                  sprite_valid_out
);
   localparam int ADDR_W = $clog2(4 * WIDTH * HEIGHT);
   localparam int IDX_W = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
   localparam logic [10:0] WIN_LO = 11'(TARGET_Y - TOL);
   localparam logic [10:0] WIN_HI = 11'(TARGET_Y + TOL);
   slot_t slots [NUM_SLOTS];
   sched_state_t state;
   logic [IDX_W-1:0] idx, free_idx, hit_idx;
   logic pend_hit, hit_r, miss_r, free_any, hit_found, sel_hit, eff_hit, spawn_fire;
   logic [1:0] pend_dir, eff_dir;
   logic [10:0] ny;
   logic [2:0] valid_pipe;
   logic [NUM_SLOTS-1:0] pix_hit;
   logic [ADDR_W-1:0] pix_addr [NUM_SLOTS];
   logic [ADDR_W-1:0] sel_addr;

   assign bus.spawn_ready_out = state == IDLE && free_any;
   assign bus.hit_out = hit_r;
   assign bus.miss_out = miss_r;
   assign sprite_valid_out = valid_pipe[2];
   assign spawn_fire = bus.spawn_valid_in && state == IDLE && free_any;
   // a fresh press in IDLE supersedes a press left pending from the sweep
   assign eff_hit = state == IDLE && (bus.hit_in || pend_hit);
   assign eff_dir = bus.hit_in ? bus.hit_dir_in : pend_dir;
   assign ny = {1'b0, slots[idx].y} + 11'(SPEED);

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
      sprite_hit_test #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_hit (
         .slot(slots[g]), .hcount(hcount_in), .vcount(vcount_in), .hit(pix_hit[g]), .addr(pix_addr[g]));
   end

   // descending scan so the lowest qualifying index wins each search
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      hit_found = 1'b0;
      hit_idx = '0;
      sel_hit = 1'b0;
      sel_addr = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!slots[i].active) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
         if (eff_hit && slots[i].active && slots[i].dir == arrow_dir_t'(eff_dir) &&
             {1'b0, slots[i].y} >= WIN_LO && {1'b0, slots[i].y} <= WIN_HI) begin
            hit_found = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (pix_hit[i]) begin
            sel_hit = 1'b1;
            sel_addr = pix_addr[i];
         end
      end
   end

   always_ff @(posedge pixel_clk_in) begin
      if (!rst_in) begin
         for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
         state <= IDLE;
         idx <= '0;
         pend_hit <= 1'b0;
         pend_dir <= 2'd0;
         hit_r <= 1'b0;
         miss_r <= 1'b0;
         rom_addr_out <= '0;
         valid_pipe <= '0;
      end else begin
         hit_r <= 1'b0;
         miss_r <= 1'b0;
         rom_addr_out <= sel_hit ? sel_addr : '0;
         valid_pipe <= {valid_pipe[1:0], sel_hit};
         if (state == IDLE) begin
            pend_hit <= 1'b0;
            if (spawn_fire) slots[free_idx] <= '{active: 1'b1, dir: arrow_dir_t'(bus.spawn_dir_in), y: 10'd0};
            if (hit_found) begin
               slots[hit_idx] <= '0;
               hit_r <= 1'b1;
            end
            if (new_frame_in) begin
               state <= UPDATE;
               idx <= '0;
            end
         end else begin
            if (bus.hit_in) begin
               pend_hit <= 1'b1;
               pend_dir <= bus.hit_dir_in;
            end
            if (slots[idx].active) begin
               if (ny >= 11'(SCREEN_H)) begin
                  slots[idx] <= '0;
                  miss_r <= 1'b1;
               end else slots[idx].y <= ny[9:0];
            end
            idx <= idx + 1'b1;
            if (idx == IDX_W'(NUM_SLOTS - 1)) state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_arrow_scheduler.sv
// tb_arrow_scheduler: directed self-checking bench for arrow_scheduler
module tb_arrow_scheduler;
   logic clk = 1'b0;
   logic rst_n;
   logic [10:0] hcount;
   logic [9:0] vcount;
   logic new_frame;
   logic [15:0] rom_addr;
   logic sprite_valid;
   int checks = 0;
   int errors = 0;
   int miss_cnt = 0;

   arrow_scheduler_if bus();
   arrow_scheduler dut (
      .pixel_clk_in(clk), .rst_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
      .new_frame_in(new_frame), .bus(bus), .rom_addr_out(rom_addr), .sprite_valid_out(sprite_valid));

   always #5 clk = ~clk;
   always @(negedge clk) if (bus.miss_out) miss_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      bus.spawn_valid_in = 1'b0;
      bus.spawn_dir_in = 2'd0;
      bus.hit_in = 1'b0;
      bus.hit_dir_in = 2'd0;
      new_frame = 1'b0;
      hcount = '0;
      vcount = '0;
      tick;
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         new_frame = 1'b1;
         tick;
         new_frame = 1'b0;
         repeat (4) tick;
      end
   endtask

   task automatic spawn(input logic [1:0] d);
      int n = 0;
      while (!bus.spawn_ready_out && n < 20) begin
         tick;
         n++;
      end
      checks++;
      if (bus.spawn_ready_out !== 1'b1) begin
         errors++;
         $display("FAIL spawn_wait ready got %0b exp 1", bus.spawn_ready_out);
      end
      bus.spawn_valid_in = 1'b1;
      bus.spawn_dir_in = d;
      tick;
      bus.spawn_valid_in = 1'b0;
   endtask

   task automatic press(input logic [1:0] d);
      bus.hit_in = 1'b1;
      bus.hit_dir_in = d;
      tick;
      bus.hit_in = 1'b0;
   endtask

   task automatic probe(input int h, input int v, output int a, output logic s1, output logic s3);
      hcount = 11'(h);
      vcount = 10'(v);
      tick;
      a = int'(rom_addr);
      s1 = sprite_valid;
      hcount = '0;
      vcount = '0;
      tick;
      tick;
      s3 = sprite_valid;
   endtask

   task automatic test_reset;
      do_reset;
      checks++; if (bus.spawn_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", bus.spawn_ready_out); end
      checks++; if (bus.hit_out !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b exp 0", bus.hit_out); end
      checks++; if (bus.miss_out !== 1'b0) begin errors++; $display("FAIL reset_miss got %0b exp 0", bus.miss_out); end
      checks++; if (rom_addr !== 16'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rom_addr); end
      checks++; if (sprite_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", sprite_valid); end
   endtask

   task automatic test_spawn_move;
      int a;
      logic s1, s3;
      do_reset;
      spawn(2'd1);
      probe(350, 0, a, s1, s3);
      checks++; if (a != 10000) begin errors++; $display("FAIL spawn_addr got %0d exp 10000", a); end
      frames(10);
      probe(355, 21, a, s1, s3);
      checks++; if (a != 10105) begin errors++; $display("FAIL move_addr got %0d exp 10105", a); end
      checks++; if (s1 !== 1'b0) begin errors++; $display("FAIL move_valid_early got %0b exp 0", s1); end
      checks++; if (s3 !== 1'b1) begin errors++; $display("FAIL move_valid_3cyc got %0b exp 1", s3); end
      probe(355, 19, a, s1, s3);
      checks++; if (a != 0 || s3 !== 1'b0) begin errors++; $display("FAIL above_box addr %0d valid %0b exp 0 0", a, s3); end
   endtask

   task automatic test_frame_ignore;
      int a;
      logic s1, s3;
      do_reset;
      spawn(2'd0);
      new_frame = 1'b1;
      repeat (3) tick;
      new_frame = 1'b0;
      repeat (4) tick;
      probe(201, 2, a, s1, s3);
      checks++; if (a != 1) begin errors++; $display("FAIL frame_ignore addr got %0d exp 1", a); end
   endtask

   task automatic test_full;
      int a, m0;
      logic s1, s3;
      do_reset;
      spawn(2'd0);
      frames(200);
      spawn(2'd1);
      spawn(2'd2);
      spawn(2'd2);
      checks++; if (bus.spawn_ready_out !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", bus.spawn_ready_out); end
      bus.spawn_valid_in = 1'b1;
      bus.spawn_dir_in = 2'd3;
      repeat (3) tick;
      checks++; if (bus.spawn_ready_out !== 1'b0) begin errors++; $display("FAIL held_ready got %0b exp 0", bus.spawn_ready_out); end
      bus.spawn_valid_in = 1'b0;
      m0 = miss_cnt;
      frames(184);
      checks++; if (miss_cnt - m0 != 1) begin errors++; $display("FAIL full_miss count got %0d exp 1", miss_cnt - m0); end
      checks++; if (bus.spawn_ready_out !== 1'b1) begin errors++; $display("FAIL freed_ready got %0b exp 1", bus.spawn_ready_out); end
      bus.spawn_valid_in = 1'b1;
      bus.spawn_dir_in = 2'd3;
      tick;
      bus.spawn_valid_in = 1'b0;
      checks++; if (bus.spawn_ready_out !== 1'b0) begin errors++; $display("FAIL refill_ready got %0b exp 0", bus.spawn_ready_out); end
      probe(650, 0, a, s1, s3);
      checks++; if (a != 30000) begin errors++; $display("FAIL refill_addr got %0d exp 30000", a); end
   endtask

   task automatic test_miss;
      int a, m0;
      logic s1, s3;
      do_reset;
      spawn(2'd0);
      m0 = miss_cnt;
      frames(383);
      checks++; if (miss_cnt != m0) begin errors++; $display("FAIL early_miss count got %0d exp 0", miss_cnt - m0); end
      probe(201, 767, a, s1, s3);
      checks++; if (a != 101) begin errors++; $display("FAIL y766_addr got %0d exp 101", a); end
      frames(1);
      checks++; if (miss_cnt - m0 != 1) begin errors++; $display("FAIL miss_pulse count got %0d exp 1", miss_cnt - m0); end
      probe(201, 767, a, s1, s3);
      checks++; if (a != 0 || s3 !== 1'b0) begin errors++; $display("FAIL miss_cleared addr %0d valid %0b exp 0 0", a, s3); end
   endtask

   task automatic test_hit;
      int a;
      logic s1, s3;
      do_reset;
      spawn(2'd2);
      frames(250);
      press(2'd2);
      checks++; if (bus.hit_out !== 1'b0) begin errors++; $display("FAIL hit_y500 got %0b exp 0", bus.hit_out); end
      frames(45);
      press(2'd3);
      checks++; if (bus.hit_out !== 1'b0) begin errors++; $display("FAIL hit_wrong_dir got %0b exp 0", bus.hit_out); end
      probe(502, 593, a, s1, s3);
      checks++; if (a != 20302) begin errors++; $display("FAIL y590_addr got %0d exp 20302", a); end
      press(2'd2);
      checks++; if (bus.hit_out !== 1'b1) begin errors++; $display("FAIL hit_y590 got %0b exp 1", bus.hit_out); end
      tick;
      checks++; if (bus.hit_out !== 1'b0) begin errors++; $display("FAIL hit_one_cycle got %0b exp 0", bus.hit_out); end
      probe(502, 593, a, s1, s3);
      checks++; if (a != 0) begin errors++; $display("FAIL hit_cleared addr got %0d exp 0", a); end
   endtask

   task automatic test_window;
      do_reset;
      spawn(2'd0);
      frames(289);
      press(2'd0);
      checks++; if (bus.hit_out !== 1'b0) begin errors++; $display("FAIL win_y578 got %0b exp 0", bus.hit_out); end
      frames(1);
      press(2'd0);
      checks++; if (bus.hit_out !== 1'b1) begin errors++; $display("FAIL win_y580 got %0b exp 1", bus.hit_out); end
      spawn(2'd0);
      frames(310);
      press(2'd0);
      checks++; if (bus.hit_out !== 1'b1) begin errors++; $display("FAIL win_y620 got %0b exp 1", bus.hit_out); end
   endtask

   task automatic test_pending;
      int a;
      logic s1, s3;
      do_reset;
      spawn(2'd0);
      frames(295);
      new_frame = 1'b1;
      tick;
      new_frame = 1'b0;
      press(2'd0);
      repeat (3) tick;
      checks++; if (bus.hit_out !== 1'b0) begin errors++; $display("FAIL pend_early got %0b exp 0", bus.hit_out); end
      tick;
      checks++; if (bus.hit_out !== 1'b1) begin errors++; $display("FAIL pend_hit got %0b exp 1", bus.hit_out); end
      tick;
      checks++; if (bus.hit_out !== 1'b0) begin errors++; $display("FAIL pend_one_cycle got %0b exp 0", bus.hit_out); end
      probe(201, 593, a, s1, s3);
      checks++; if (a != 0) begin errors++; $display("FAIL pend_cleared addr got %0d exp 0", a); end
   endtask

   task automatic test_reset_mid;
      int a, m0;
      logic s1, s3;
      do_reset;
      spawn(2'd0);
      frames(383);
      m0 = miss_cnt;
      new_frame = 1'b1;
      tick;
      new_frame = 1'b0;
      hcount = 11'd201;
      vcount = 10'd767;
      rst_n = 1'b0;
      tick;
      checks++; if (bus.miss_out !== 1'b0) begin errors++; $display("FAIL mid_miss got %0b exp 0", bus.miss_out); end
      checks++; if (bus.hit_out !== 1'b0) begin errors++; $display("FAIL mid_hit got %0b exp 0", bus.hit_out); end
      checks++; if (rom_addr !== 16'd0) begin errors++; $display("FAIL mid_addr got %0d exp 0", rom_addr); end
      checks++; if (sprite_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b exp 0", sprite_valid); end
      rst_n = 1'b1;
      hcount = '0;
      vcount = '0;
      repeat (6) tick;
      checks++; if (miss_cnt != m0) begin errors++; $display("FAIL mid_no_miss count got %0d exp 0", miss_cnt - m0); end
      checks++; if (bus.spawn_ready_out !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b exp 1", bus.spawn_ready_out); end
      probe(201, 767, a, s1, s3);
      checks++; if (a != 0) begin errors++; $display("FAIL mid_cleared addr got %0d exp 0", a); end
   endtask

   initial begin
      test_reset;
      test_spawn_move;
      test_frame_ignore;
      test_full;
      test_miss;
      test_hit;
      test_window;
      test_pending;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
